// File: rtl/panel_scan_ctrl_pkg.sv
// Shared panel definitions: scan state encoding and default panel geometry,
// common to the scan controller, the RGB PWM comparator and the pixel RAM.
package panel_scan_ctrl_pkg;

  typedef enum logic [2:0] {
    IDLE,
    S_ADDR,
    S_SETUP,
    S_CLK,
    BLANK,
    LATCH
  } scan_state_t;

  localparam int DEF_PWM_WIDTH    = 8;
  localparam int DEF_COLS         = 32;
  localparam int DEF_COL_BITS     = 5;
  localparam int DEF_ROW_BITS     = 4;
  localparam int DEF_BLANK_CYCLES = 2;

endpackage

// File: rtl/panel_scan_ctrl.sv
// HUB75 scan generator: walks row / PWM step / column, one 3-cycle column slot, then blank and latch.
// All outputs registered; no backpressure, enable is only honoured in IDLE and at LATCH.
module panel_scan_ctrl
  import panel_scan_ctrl_pkg::*;
#(
  parameter int PWM_WIDTH    = DEF_PWM_WIDTH,
  parameter int COLS         = DEF_COLS,
  parameter int COL_BITS     = DEF_COL_BITS,
  parameter int ROW_BITS     = DEF_ROW_BITS,
  parameter int BLANK_CYCLES = DEF_BLANK_CYCLES
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 enable,
  output logic [PWM_WIDTH-1:0] pwm,
  output logic [ROW_BITS-1:0]  fetch_row,
  output logic [COL_BITS-1:0]  fetch_col,
  output logic                 sclk,
  output logic                 latch,
  output logic                 oe_n,
  output logic [ROW_BITS-1:0]  row_addr,
  output logic                 frame_start
);

  localparam int BLK_BITS = (BLANK_CYCLES > 1) ? $clog2(BLANK_CYCLES) : 1;
  localparam logic [COL_BITS-1:0] COL_LAST   = COL_BITS'(COLS - 1);
  localparam logic [BLK_BITS-1:0] BLANK_LAST = BLK_BITS'(BLANK_CYCLES - 1);

  scan_state_t          state, state_nxt;
  logic [BLK_BITS-1:0]  blank_cnt, blank_nxt;
  logic [COL_BITS-1:0]  col_nxt;
  logic [PWM_WIDTH-1:0] pwm_nxt;
  logic [ROW_BITS-1:0]  row_nxt;
  logic [ROW_BITS-1:0]  row_addr_nxt;
  logic                 shown, shown_nxt;
  logic                 frame_nxt;
  logic                 shift_nxt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      blank_cnt   <= '0;
      shown       <= 1'b0;
      pwm         <= '0;
      fetch_row   <= '0;
      fetch_col   <= '0;
      sclk        <= 1'b0;
      latch       <= 1'b0;
      oe_n        <= 1'b1;
      row_addr    <= '0;
      frame_start <= 1'b0;
    end else begin
      state       <= state_nxt;
      blank_cnt   <= blank_nxt;
      shown       <= shown_nxt;
      pwm         <= pwm_nxt;
      fetch_row   <= row_nxt;
      fetch_col   <= col_nxt;
      sclk        <= (state_nxt == S_CLK);
      latch       <= (state_nxt == LATCH);
      oe_n        <= !(shift_nxt && shown_nxt);
      row_addr    <= row_addr_nxt;
      frame_start <= frame_nxt;
    end
  end

  always_comb begin
    state_nxt    = state;
    blank_nxt    = blank_cnt;
    shown_nxt    = shown;
    pwm_nxt      = pwm;
    row_nxt      = fetch_row;
    col_nxt      = fetch_col;
    row_addr_nxt = row_addr;
    frame_nxt    = 1'b0;

    case (state)
      IDLE: begin
        if (enable) begin
          state_nxt = S_ADDR;
        end
      end
      S_ADDR:  state_nxt = S_SETUP;
      S_SETUP: state_nxt = S_CLK;
      S_CLK: begin
        if (fetch_col == COL_LAST) begin
          state_nxt = BLANK;
          blank_nxt = '0;
        end else begin
          state_nxt = S_ADDR;
          col_nxt   = fetch_col + COL_BITS'(1);
        end
      end
      BLANK: begin
        if (blank_cnt == BLANK_LAST) begin
          state_nxt    = LATCH;
          row_addr_nxt = fetch_row;
          shown_nxt    = 1'b1;
        end else begin
          blank_nxt = blank_cnt + BLK_BITS'(1);
        end
      end
      LATCH: begin
        col_nxt = '0;
        pwm_nxt = pwm + PWM_WIDTH'(1);
        if (pwm == '1) begin
          row_nxt = fetch_row + ROW_BITS'(1);
        end
        if (enable) begin
          state_nxt = S_ADDR;
          frame_nxt = (pwm == '1) && (fetch_row == '1);
        end else begin
          // Stopping drops straight back to the reset picture, including row_addr.
          state_nxt    = IDLE;
          pwm_nxt      = '0;
          row_nxt      = '0;
          row_addr_nxt = '0;
          shown_nxt    = 1'b0;
        end
      end
      default: state_nxt = IDLE;
    endcase

    shift_nxt = (state_nxt == S_ADDR) || (state_nxt == S_SETUP) || (state_nxt == S_CLK);
  end

endmodule

// File: tb/tb_panel_scan_ctrl.sv
// Bench for panel_scan_ctrl: per-cycle comparison against a slot/phase timing model plus
// directed literal checks. PWM and row widths are reduced so a whole frame fits a short run.
module tb_panel_scan_ctrl;

  localparam int PW    = 4;
  localparam int NC    = 32;
  localparam int CB    = 5;
  localparam int RB    = 2;
  localparam int BLK   = 2;
  localparam int SLOT  = 3 * NC + BLK + 1;
  localparam int NPWM  = 1 << PW;
  localparam int NROW  = 1 << RB;
  localparam int FRAME_SLOTS = NPWM * NROW;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          enable = 1'b0;
  logic [PW-1:0] pwm;
  logic [RB-1:0] fetch_row;
  logic [CB-1:0] fetch_col;
  logic          sclk;
  logic          latch;
  logic          oe_n;
  logic [RB-1:0] row_addr;
  logic          frame_start;

  int n_checks = 0;
  int n_fail   = 0;

  panel_scan_ctrl #(
    .PWM_WIDTH(PW), .COLS(NC), .COL_BITS(CB), .ROW_BITS(RB), .BLANK_CYCLES(BLK)
  ) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .pwm(pwm), .fetch_row(fetch_row),
    .fetch_col(fetch_col), .sclk(sclk), .latch(latch), .oe_n(oe_n),
    .row_addr(row_addr), .frame_start(frame_start)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Model: m_t counts cycles since the first column-0 address cycle of the current run.
  logic m_active = 1'b0;
  int   m_t = 0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_active <= 1'b0;
      m_t      <= 0;
    end else if (!m_active) begin
      if (enable) begin
        m_active <= 1'b1;
        m_t      <= 0;
      end
    end else if ((m_t % SLOT == SLOT - 1) && !enable) begin
      m_active <= 1'b0;
    end else begin
      m_t <= m_t + 1;
    end
  end

  logic cmp_on = 1'b0;
  int slot, ph, e_pwm, e_row, e_col, e_ra, e_sclk, e_latch, e_oe, e_fs;

  always @(negedge clk) begin
    if (cmp_on) begin
      if (!m_active) begin
        e_pwm = 0; e_row = 0; e_col = 0; e_ra = 0;
        e_sclk = 0; e_latch = 0; e_oe = 1; e_fs = 0;
      end else begin
        slot  = m_t / SLOT;
        ph    = m_t % SLOT;
        e_pwm = slot % NPWM;
        e_row = (slot / NPWM) % NROW;
        if (ph < 3 * NC) begin
          e_col  = ph / 3;
          e_sclk = (ph % 3 == 2) ? 1 : 0;
          e_oe   = (slot == 0) ? 1 : 0;
        end else begin
          e_col  = NC - 1;
          e_sclk = 0;
          e_oe   = 1;
        end
        e_latch = (ph == SLOT - 1) ? 1 : 0;
        if (e_latch == 1)   e_ra = e_row;
        else if (slot == 0) e_ra = 0;
        else                e_ra = ((slot - 1) / NPWM) % NROW;
        e_fs = (ph == 0 && slot > 0 && slot % FRAME_SLOTS == 0) ? 1 : 0;
      end
      chk("pwm",         int'(pwm),         e_pwm);
      chk("fetch_row",   int'(fetch_row),   e_row);
      chk("fetch_col",   int'(fetch_col),   e_col);
      chk("sclk",        int'(sclk),        e_sclk);
      chk("latch",       int'(latch),       e_latch);
      chk("oe_n",        int'(oe_n),        e_oe);
      chk("row_addr",    int'(row_addr),    e_ra);
      chk("frame_start", int'(frame_start), e_fs);
    end
  end

  // Event counters for the directed checks.
  logic prev_sclk = 1'b0;
  int rises = 0, latches = 0, fs_cnt = 0, fs_t = -1, last_rise = -1;

  always @(negedge clk) begin
    if (sclk && !prev_sclk) begin
      rises     <= rises + 1;
      last_rise <= m_t;
    end
    if (latch)       latches <= latches + 1;
    if (frame_start) begin
      fs_cnt <= fs_cnt + 1;
      fs_t   <= m_t;
    end
    prev_sclk <= sclk;
  end

  int base_r, base_l;

  initial begin
    repeat (3) @(negedge clk);
    chk("rst_oe_n", int'(oe_n), 1);
    chk("rst_sclk", int'(sclk), 0);
    rst_n  = 1'b1;
    cmp_on = 1'b1;

    // Idle with enable low.
    repeat (20) @(negedge clk);
    chk("idle_sclk_edges", rises, 0);
    chk("idle_latches", latches, 0);

    // Continuous run through one full frame.
    base_r = rises;
    enable = 1'b1;
    for (int c = 0; c < FRAME_SLOTS * SLOT + 20; c++) begin
      @(negedge clk);
      if (c == 0)             chk("c1_fetch_col", int'(fetch_col), 0);
      if (c == 3)             chk("first_rise", rises - base_r, 1);
      if (c == 97)            chk("c98_oe_n", int'(oe_n), 1);
      if (c == 98)            chk("c99_latch", int'(latch), 1);
      if (c == SLOT - 1) begin
        chk("pass0_rises", rises - base_r, 32);
        chk("pass0_last_rise", last_rise, 95);
      end
      if (c == 99)            chk("c100_pwm", int'(pwm), 1);
      if (c == 101)           chk("pass1_oe_n", int'(oe_n), 0);
      if (c == NPWM*SLOT - 1) chk("pre_wrap_pwm", int'(pwm), NPWM - 1);
      if (c == NPWM*SLOT) begin
        chk("wrap_pwm", int'(pwm), 0);
        chk("wrap_row", int'(fetch_row), 1);
      end
      if (c == NPWM*SLOT + 5) chk("slot_row_addr", int'(row_addr), 0);
      if (c == (NPWM+1)*SLOT) chk("after_latch_row_addr", int'(row_addr), 1);
      if (c == FRAME_SLOTS*SLOT) begin
        chk("frame_pulse", int'(frame_start), 1);
        chk("frame_row", int'(fetch_row), 0);
        chk("frame_pwm", int'(pwm), 0);
      end
    end
    chk("frame_pulse_count", fs_cnt, 1);
    chk("frame_pulse_time", fs_t, FRAME_SLOTS * SLOT);

    // Drop enable during column 10.
    for (int k = 0; k < 2 * SLOT && !(fetch_col == 5'd10 && !sclk); k++) @(negedge clk);
    chk("reach_col10", int'(fetch_col), 10);
    enable = 1'b0;
    base_r = rises;
    base_l = latches;
    repeat (2 * SLOT) @(negedge clk);
    chk("drop_rises", rises - base_r, 22);
    chk("drop_latches", latches - base_l, 1);
    chk("drop_oe_n", int'(oe_n), 1);
    chk("drop_pwm", int'(pwm), 0);
    chk("drop_row", int'(fetch_row), 0);

    // Reset asserted during BLANK.
    enable = 1'b1;
    for (int k = 0; k < 3 * SLOT && !(m_active && m_t == 96); k++) @(negedge clk);
    chk("reach_blank", int'(m_active && m_t == 96), 1);
    #2 rst_n = 1'b0;
    base_l = latches;
    #1;
    chk("arst_oe_n", int'(oe_n), 1);
    chk("arst_latch", int'(latch), 0);
    chk("arst_col", int'(fetch_col), 0);
    repeat (3) @(negedge clk);
    chk("arst_no_latch", latches - base_l, 0);
    #2 rst_n = 1'b1;
    for (int c = 0; c < SLOT + 2; c++) begin
      @(negedge clk);
      if (c == 0) begin
        chk("restart_pwm", int'(pwm), 0);
        chk("restart_row", int'(fetch_row), 0);
      end
      if (c == SLOT) chk("restart_pwm_next", int'(pwm), 1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
